// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle control FSM with memory wait states, ready handshake and sticky illegal trap.
module multicycle_control_unit #(
  parameter int MEM_WAIT  = 0,
  parameter int USE_READY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Illegal,
  output logic [3:0] State
);
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXEC_R  = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] EXEC_I  = 4'd9;
  localparam logic [3:0] JAL     = 4'd10;
  localparam logic [3:0] JALR    = 4'd11;
  localparam logic [3:0] LUI     = 4'd12;
  localparam logic [3:0] ILLEGAL = 4'd14;
  localparam logic [3:0] WAIT    = 4'(MEM_WAIT);
  logic [3:0] state, next, cnt;
  logic       ill, done;
  assign done    = cnt == WAIT && (USE_READY == 0 || MemReady);
  assign State   = state;
  assign Illegal = ill;
  always_comb begin
    next = ILLEGAL;
    case (state)
      FETCH:  next = done ? DECODE : FETCH;
      DECODE:
        case (op)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011: next = EXEC_R;
          7'b0010011: next = EXEC_I;
          7'b1100011: next = BRANCH;
          7'b1101111: next = JAL;
          7'b1100111: next = JALR;
          7'b0110111: next = LUI;
          7'b0010111: next = ALUWB;
          7'b0001111: next = FETCH;
          default:    next = ILLEGAL;
        endcase
      MEMADR: next = op == 7'b0100011 ? MEMWR : MEMRD;
      MEMRD:  next = done ? MEMWB : MEMRD;
      MEMWR:  next = done ? FETCH : MEMWR;
      EXEC_R, EXEC_I, LUI: next = ALUWB;
      MEMWB, ALUWB, BRANCH, JAL, JALR: next = FETCH;
      default: next = ILLEGAL;
    endcase
  end
  // The wait counter restarts whenever the state changes and saturates while a state is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
      ill   <= 1'b0;
    end else begin
      state <= next;
      cnt   <= next != state ? '0 : cnt == WAIT ? cnt : cnt + 4'd1;
      ill   <= ill | (next == ILLEGAL);
    end
  end
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        IRWrite = done;
        PCWrite = done;
      end
      DECODE: ALUSrcB = 2'b10;
      MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b01;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      JALR: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      LUI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      default: ;
    endcase
    if (!rst_n) {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite} = '0;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized check of three parameterisations against a per-instruction state-path model.
module tb_multicycle_control_unit;
  localparam logic [17:0] EN = 18'h37800;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0][6:0] opv;
  logic [2:0] rdy;
  logic [2:0][17:0] ctl;
  logic [2:0][3:0] st;
  int checks = 0;
  int errors = 0;
  logic [6:0] legal [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    logic pcw, pwc, iord, mr, mw, irw, rw, ill;
    logic [1:0] m2r, pcs, aop, sa, sb;
    logic [3:0] s;
    multicycle_control_unit #(.MEM_WAIT(g == 1 ? 2 : g == 2 ? 1 : 0), .USE_READY(g == 2 ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .op(opv[g]), .MemReady(rdy[g]),
      .PCWrite(pcw), .PCWriteCond(pwc), .IorD(iord), .MemRead(mr), .MemWrite(mw),
      .IRWrite(irw), .RegWrite(rw), .MemtoReg(m2r), .PCSource(pcs), .ALUOp(aop),
      .ALUSrcA(sa), .ALUSrcB(sb), .Illegal(ill), .State(s));
    assign ctl[g] = {pcw, pwc, iord, mr, mw, irw, rw, m2r, pcs, aop, sa, sb, ill};
    assign st[g]  = s;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [17:0] exp_ctl(input logic [3:0] s, input bit done);
    logic pcw, pwc, iord, mr, mw, irw, rw, ill;
    logic [1:0] m2r, pcs, aop, sa, sb;
    {pcw, pwc, iord, mr, mw, irw, rw, ill} = '0;
    {m2r, pcs, aop, sa, sb} = '0;
    case (s)
      0:  begin mr = 1; sa = 3; sb = 1; irw = done; pcw = done; end
      1:  sb = 2;
      2:  begin sa = 1; sb = 2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2; end
      7:  rw = 1;
      8:  begin sa = 1; aop = 1; pwc = 1; pcs = 1; end
      9:  begin sa = 1; sb = 2; aop = 3; end
      10: begin pcw = 1; pcs = 1; rw = 1; m2r = 2; end
      11: begin sa = 1; sb = 2; pcw = 1; rw = 1; m2r = 2; end
      12: begin sa = 2; sb = 2; end
      default: ill = 1;
    endcase
    return {pcw, pwc, iord, mr, mw, irw, rw, m2r, pcs, aop, sa, sb, ill};
  endfunction
  // State path of one instruction, first state in the low nibble, terminated by F.
  function automatic logic [27:0] path_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 28'hFF43210;
      7'b0100011: return 28'hFFF5210;
      7'b0110011: return 28'hFFF7610;
      7'b0010011: return 28'hFFF7910;
      7'b1100011: return 28'hFFFF810;
      7'b1101111: return 28'hFFFFA10;
      7'b1100111: return 28'hFFFFB10;
      7'b0110111: return 28'hFFF7C10;
      7'b0010111: return 28'hFFFF710;
      7'b0001111: return 28'hFFFFF10;
      default:    return 28'hFFFFE10;
    endcase
  endfunction
  function automatic bit is_legal(input logic [6:0] o);
    foreach (legal[i]) if (legal[i] == o) return 1'b1;
    return 1'b0;
  endfunction
  task automatic run(input int k, input int n);
    int mw, lowlen, low, c;
    bit ur, r, dn;
    logic [27:0] p;
    logic [6:0] o;
    logic [3:0] s;
    mw = k == 1 ? 2 : k == 2 ? 1 : 0;
    ur = k == 2;
    for (int i = 0; i <= n; i++) begin
      if (i < n) o = legal[$urandom_range(0, 9)];
      else do o = 7'($urandom); while (is_legal(o));
      opv[k] = o;
      p = path_of(o);
      for (int j = 0; p[4*j +: 4] != 4'hF; j++) begin
        s = p[4*j +: 4];
        lowlen = $urandom_range(0, 4);
        low = 0;
        c = 0;
        forever begin
          if (s == 0 || s == 3 || s == 5) begin
            if (c < mw) r = 1'($urandom_range(0, 1));
            else begin r = low >= lowlen; low++; end
            dn = c >= mw && (!ur || r);
          end else begin
            r = 1'($urandom_range(0, 1));
            dn = 1'b1;
          end
          rdy[k] = r;
          #1;
          chk($sformatf("state[%0d] op=%b", k, o), 32'(st[k]), 32'(s));
          chk($sformatf("ctl[%0d] st=%0d", k, s), 32'(ctl[k]), 32'(exp_ctl(s, dn)));
          @(negedge clk);
          if (dn) break;
          c++;
        end
      end
    end
    repeat (10) begin
      rdy[k] = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("ill_state[%0d]", k), 32'(st[k]), 32'd14);
      chk($sformatf("ill_ctl[%0d]", k), 32'(ctl[k]), 32'(exp_ctl(4'd14, 1'b0)));
      @(negedge clk);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    opv = '0;
    rdy = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_state[%0d]", k), 32'(st[k]), 32'd0);
        chk($sformatf("rst_ctl[%0d]", k), 32'(ctl[k]), 32'(exp_ctl(4'd0, 1'b0) & ~EN));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    fork
      run(0, 40);
      run(1, 40);
      run(2, 40);
    join
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_state[%0d]", k), 32'(st[k]), 32'd0);
      chk($sformatf("arst_ctl[%0d]", k), 32'(ctl[k]), 32'(exp_ctl(4'd0, 1'b0) & ~EN));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      run(0, 6);
      run(1, 6);
      run(2, 6);
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
